// File: rtl/copy_mem_pkg.sv
// Shared types and width helpers for the rx packet buffer.
// Analyzer state codes carry a frame-error flag in bit 7.
package copy_mem_pkg;

  localparam int FRAME_ERR_BIT = 7;

  typedef enum logic [7:0] {
    AN_IDLE     = 8'h00,
    AN_PREAMBLE = 8'h01,
    AN_HEADER   = 8'h02,
    AN_PAYLOAD  = 8'h03,
    AN_FCS      = 8'h04,
    AN_ERROR    = 8'h80
  } an_state_e;

  typedef enum logic [1:0] {
    WR_WAIT,
    WR_IDLE,
    WR_RECV,
    WR_DROP
  } wr_state_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/copy_packet_to_mem_core_len_fifo.sv
// Show-ahead length FIFO; one entry per committed packet.
// Push is honoured when full only if a pop happens on the same edge.
module len_fifo
  import copy_mem_pkg::*;
#(
  parameter int pWIDTH = 16,
  parameter int pDEPTH = 56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [pWIDTH-1:0] din,
  output logic [pWIDTH-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = ptr_w(pDEPTH);
  localparam int CW = cnt_w(pDEPTH);
  localparam logic [AW-1:0] ADDR_LAST = AW'(pDEPTH - 1);

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]     wa;
  logic [AW-1:0]     ra;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(pDEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[ra];

  always_ff @(posedge clk) begin
    if (do_push) mem[wa] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa  <= '0;
      ra  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wa <= (wa == ADDR_LAST) ? '0 : wa + AW'(1);
      if (do_pop)  ra <= (ra == ADDR_LAST) ? '0 : ra + AW'(1);
      if (do_push & ~do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop & ~do_push) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/copy_packet_to_mem_core.sv
// Rx packet buffer: circular byte RAM plus a FIFO of good-frame lengths.
// Frames are written speculatively and rolled back unless committed.
module copy_packet_to_mem_core
  import copy_mem_pkg::*;
#(
  parameter int pFIFO_WIDTH        = 16,
  parameter int pFIFO_DEPTH        = 56,
  parameter int pDATA_WIDTH        = 8,
  parameter int pDEPTH_RAM         = 3072,
  parameter int pMAX_PACKET_LENGHT = 1536
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic                   idv,
  input  logic [pDATA_WIDTH-1:0] irx_d,
  input  logic                   irx_er,
  input  logic [7:0]             iframe_state,
  input  logic                   ird_en,
  output logic                   oempty,
  output logic                   ofull,
  output logic [pDATA_WIDTH-1:0] or_data,
  output logic [pFIFO_WIDTH-1:0] olen_pac,
  output logic                   onext_last,
  output logic [pFIFO_WIDTH-1:0] obytes_to_read,
  output logic                   ofifo_em,
  output logic                   ofifo_full
);

  localparam int PW = ptr_w(pDEPTH_RAM);
  localparam int UW = cnt_w(pDEPTH_RAM);
  localparam int LW = pFIFO_WIDTH;
  localparam logic [PW-1:0] PTR_LAST  = PW'(pDEPTH_RAM - 1);
  localparam logic [UW-1:0] RAM_BYTES = UW'(pDEPTH_RAM);
  localparam logic [UW-1:0] MAX_BYTES = UW'(pMAX_PACKET_LENGHT);
  localparam logic [LW-1:0] MAX_LEN   = LW'(pMAX_PACKET_LENGHT);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  wr_state_e state;
  wr_state_e state_nxt;

  logic [pDATA_WIDTH-1:0] ram [pDEPTH_RAM];
  logic [PW-1:0] wptr;
  logic [PW-1:0] cptr;
  logic [PW-1:0] rptr;
  logic [UW-1:0] used;
  logic [LW-1:0] len;
  logic [LW-1:0] btr;
  logic [LW-1:0] len_pac;
  logic [LW-1:0] head;
  logic          rx_err;
  logic          over;
  logic          rd_act;
  logic          admit;
  logic          frame_ok;
  logic          wr_en;
  logic          commit;
  logic          discard;
  logic          rd_go;
  logic          rd_done;
  logic          unused_state;

  assign unused_state = ^iframe_state[6:0];

  assign ofull    = ((RAM_BYTES - used) < MAX_BYTES) | ofifo_full;
  assign admit    = ~ofull;
  assign frame_ok = ~rx_err & ~iframe_state[FRAME_ERR_BIT]
                  & (len != '0) & ~over;
  assign rd_go    = ird_en & rd_act;
  assign rd_done  = rd_go & (btr == LW'(1));

  assign oempty         = ~rd_act;
  assign olen_pac       = len_pac;
  assign obytes_to_read = btr;
  assign onext_last     = (btr == LW'(1));

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    discard   = 1'b0;
    unique case (state)
      WR_WAIT: if (!idv) state_nxt = WR_IDLE;
      WR_IDLE: begin
        if (idv) begin
          state_nxt = admit ? WR_RECV : WR_DROP;
          wr_en     = admit;
        end
      end
      WR_RECV: begin
        if (idv) begin
          wr_en = (len != MAX_LEN);
        end else begin
          state_nxt = WR_IDLE;
          commit    = frame_ok;
          discard   = ~frame_ok;
        end
      end
      WR_DROP: if (!idv) state_nxt = WR_IDLE;
      default: state_nxt = WR_WAIT;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (wr_en) ram[wptr] <= irx_d;
  end

  // Write side: speculative wptr, rolled back to cptr on a bad frame
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state  <= WR_WAIT;
      wptr   <= '0;
      cptr   <= '0;
      len    <= '0;
      rx_err <= 1'b0;
      over   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en) begin
        wptr <= ptr_inc(wptr);
        len  <= len + LW'(1);
      end
      if (state == WR_IDLE && idv) rx_err <= irx_er;
      if (state == WR_RECV && idv) begin
        rx_err <= rx_err | irx_er;
        if (len == MAX_LEN) over <= 1'b1;
      end
      if (commit | discard) begin
        len    <= '0;
        rx_err <= 1'b0;
        over   <= 1'b0;
      end
      if (commit)  cptr <= wptr;
      if (discard) wptr <= cptr;
    end
  end

  // Read side: head loads one cycle after the FIFO becomes non-empty
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      rptr    <= '0;
      rd_act  <= 1'b0;
      btr     <= '0;
      len_pac <= '0;
      or_data <= '0;
      used    <= '0;
    end else begin
      if (!rd_act && !ofifo_em) begin
        rd_act  <= 1'b1;
        len_pac <= head;
        btr     <= head;
      end else if (rd_go) begin
        or_data <= ram[rptr];
        rptr    <= ptr_inc(rptr);
        btr     <= btr - LW'(1);
        if (rd_done) rd_act <= 1'b0;
      end
      unique case ({commit, rd_go})
        2'b10:   used <= used + UW'(len);
        2'b01:   used <= used - UW'(1);
        2'b11:   used <= used + UW'(len) - UW'(1);
        default: used <= used;
      endcase
    end
  end

  len_fifo #(
    .pWIDTH (pFIFO_WIDTH),
    .pDEPTH (pFIFO_DEPTH)
  ) u_len_fifo (
    .clk   (iclk),
    .rst   (i_rst),
    .push  (commit),
    .pop   (rd_done),
    .din   (len),
    .head  (head),
    .empty (ofifo_em),
    .full  (ofifo_full)
  );

endmodule

// File: tb/tb_copy_packet_to_mem_core.sv
// Randomised bench for copy_packet_to_mem_core against a queue-based model.
// The model stores committed bytes and lengths as plain queues.
module tb_copy_packet_to_mem_core;

  localparam int DEP  = 3072;
  localparam int MAXL = 1536;
  localparam int FD   = 56;

  logic        iclk = 1'b0;
  logic        i_rst;
  logic        idv;
  logic [7:0]  irx_d;
  logic        irx_er;
  logic [7:0]  iframe_state;
  logic        ird_en;
  logic        oempty;
  logic        ofull;
  logic [7:0]  or_data;
  logic [15:0] olen_pac;
  logic        onext_last;
  logic [15:0] obytes_to_read;
  logic        ofifo_em;
  logic        ofifo_full;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bq[$];
  int         lq[$];
  logic [7:0] cur[$];
  bit         m_active;
  int         m_btr;
  int         m_olen;
  logic [7:0] m_rdata;
  bit         m_prev_dv;
  bit         m_acc;
  bit         m_bad;
  bit         m_long;

  copy_packet_to_mem_core dut (
    .iclk           (iclk),
    .i_rst          (i_rst),
    .idv            (idv),
    .irx_d          (irx_d),
    .irx_er         (irx_er),
    .iframe_state   (iframe_state),
    .ird_en         (ird_en),
    .oempty         (oempty),
    .ofull          (ofull),
    .or_data        (or_data),
    .olen_pac       (olen_pac),
    .onext_last     (onext_last),
    .obytes_to_read (obytes_to_read),
    .ofifo_em       (ofifo_em),
    .ofifo_full     (ofifo_full)
  );

  always #5 iclk = ~iclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    lq.delete();
    cur.delete();
    m_active  = 0;
    m_btr     = 0;
    m_olen    = 0;
    m_rdata   = '0;
    m_prev_dv = 1;
    m_acc     = 0;
    m_bad     = 0;
    m_long    = 0;
  endtask

  task automatic model_step(input bit dv, input logic [7:0] d, input bit er,
                            input bit fs7, input bit rd);
    int  free;
    bit  admit;
    bit  start;
    bit  fend;
    free  = DEP - bq.size();
    admit = (free >= MAXL) && (lq.size() < FD);
    start = dv && !m_prev_dv;
    fend  = !dv && m_prev_dv;
    if (m_active) begin
      if (rd) begin
        m_rdata = bq.pop_front();
        m_btr--;
        if (m_btr == 0) begin
          void'(lq.pop_front());
          m_active = 0;
        end
      end
    end else if (lq.size() > 0) begin
      m_active = 1;
      m_btr    = lq[0];
      m_olen   = lq[0];
    end
    if (start) begin
      m_acc  = admit;
      m_bad  = 0;
      m_long = 0;
      cur.delete();
    end
    if (dv && m_acc) begin
      if (cur.size() < MAXL) cur.push_back(d);
      else m_long = 1;
      if (er) m_bad = 1;
    end
    if (fend && m_acc) begin
      if (!m_bad && !fs7 && cur.size() > 0 && !m_long) begin
        foreach (cur[i]) bq.push_back(cur[i]);
        lq.push_back(cur.size());
      end
      m_acc = 0;
    end
    m_prev_dv = dv;
  endtask

  task automatic compare();
    int free;
    free = DEP - bq.size();
    chk("oempty", 32'(oempty), 32'(!m_active));
    chk("ofifo_em", 32'(ofifo_em), 32'(lq.size() == 0));
    chk("ofifo_full", 32'(ofifo_full), 32'(lq.size() == FD));
    chk("ofull", 32'(ofull), 32'((free < MAXL) || (lq.size() == FD)));
    chk("obytes_to_read", 32'(obytes_to_read), 32'(m_btr));
    chk("onext_last", 32'(onext_last), 32'(m_btr == 1));
    chk("olen_pac", 32'(olen_pac), 32'(m_olen));
    chk("or_data", 32'(or_data), 32'(m_rdata));
  endtask

  task automatic cyc(input bit dv, input logic [7:0] d, input bit er,
                     input logic [7:0] fs, input bit rd);
    idv          = dv;
    irx_d        = d;
    irx_er       = er;
    iframe_state = fs;
    ird_en       = rd;
    @(posedge iclk);
    model_step(dv, d, er, fs[7], rd);
    #1;
    compare();
  endtask

  function automatic bit rnd_rd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic frame(input int len, input int er_at, input bit fs_bad,
                       input int rd_pct, input int gap);
    for (int i = 0; i < len; i++)
      cyc(1, 8'($urandom), (i == er_at), 8'h03, rnd_rd(rd_pct));
    cyc(0, 8'h00, 0, fs_bad ? 8'h84 : 8'h04, rnd_rd(rd_pct));
    for (int i = 0; i < gap; i++)
      cyc(0, 8'h00, 0, 8'h00, rnd_rd(rd_pct));
  endtask

  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 8'h00, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((lq.size() != 0 || m_active) && n < 8000) begin
      cyc(0, 8'h00, 0, 8'h00, 1);
      n++;
    end
    chk("drain_bound", 32'(lq.size() == 0 && !m_active), 32'd1);
    cyc(0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_or_data"}, 32'(or_data), 32'd0);
    chk({tag, "_olen_pac"}, 32'(olen_pac), 32'd0);
    chk({tag, "_onext_last"}, 32'(onext_last), 32'd0);
    chk({tag, "_obytes"}, 32'(obytes_to_read), 32'd0);
    chk({tag, "_oempty"}, 32'(oempty), 32'd1);
    chk({tag, "_ofifo_em"}, 32'(ofifo_em), 32'd1);
    chk({tag, "_ofull"}, 32'(ofull), 32'd0);
    chk({tag, "_ofifo_full"}, 32'(ofifo_full), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    #1;
    reset_literals(tag);
    repeat (2) @(posedge iclk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    idv          = 0;
    irx_d        = '0;
    irx_er       = 0;
    iframe_state = '0;
    ird_en       = 0;
    model_reset();
    @(posedge iclk);
    #1;
    do_reset("rst0");
    repeat (3) cyc(0, 8'h00, 0, 8'h00, 0);

    // 64-byte good frame and full read-back
    frame(64, -1, 0, 0, 0);
    chk("p64_fifo_em", 32'(ofifo_em), 32'd0);
    chk("p64_empty_lag", 32'(oempty), 32'd1);
    cyc(0, 8'h00, 0, 8'h00, 0);
    chk("p64_oempty", 32'(oempty), 32'd0);
    chk("p64_len", 32'(olen_pac), 32'd64);
    chk("p64_btr", 32'(obytes_to_read), 32'd64);
    rd_n(63);
    chk("p64_next_last", 32'(onext_last), 32'd1);
    rd_n(1);
    chk("p64_btr_end", 32'(obytes_to_read), 32'd0);
    chk("p64_done_empty", 32'(oempty), 32'd1);
    cyc(0, 8'h00, 0, 8'h00, 0);

    // rx error and frame-error flag both drop the frame
    frame(30, 12, 0, 0, 2);
    chk("er_fifo_em", 32'(ofifo_em), 32'd1);
    frame(25, -1, 1, 0, 2);
    chk("fs_fifo_em", 32'(ofifo_em), 32'd1);
    frame(20, -1, 0, 0, 2);
    drain();

    // fill the RAM with two max frames; second one wraps the address
    frame(MAXL, -1, 0, 0, 2);
    frame(MAXL, -1, 0, 0, 2);
    chk("fill_ofull", 32'(ofull), 32'd1);
    frame(10, -1, 0, 0, 2);
    rd_n(MAXL);
    chk("fill_ofull_clr", 32'(ofull), 32'd0);
    frame(MAXL, -1, 0, 0, 2);
    drain();

    // oversize frame is discarded
    frame(MAXL + 4, -1, 0, 0, 2);
    chk("long_fifo_em", 32'(ofifo_em), 32'd1);

    // length FIFO full, then commit concurrent with pop
    for (int i = 0; i < FD; i++) frame(1, -1, 0, 0, 1);
    chk("ff_full", 32'(ofifo_full), 32'd1);
    frame(1, -1, 0, 0, 1);
    cyc(0, 8'h00, 0, 8'h00, 1);
    cyc(0, 8'h00, 0, 8'h00, 0);
    cyc(1, 8'h5a, 0, 8'h03, 0);
    cyc(1, 8'ha5, 0, 8'h03, 0);
    cyc(0, 8'h00, 0, 8'h04, 1);
    chk("cc_not_full", 32'(ofifo_full), 32'd0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    frame(1, -1, 0, 0, 1);
    chk("cc_full_again", 32'(ofifo_full), 32'd1);
    drain();

    // randomised traffic
    for (int f = 0; f < 80; f++) begin
      int er_at;
      er_at = ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1;
      frame(int'($urandom_range(100, 1)), er_at,
            ($urandom_range(9) == 0), 50, int'($urandom_range(4)));
    end
    drain();

    // reset during a frame write
    for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 0, 8'h03, 0);
    do_reset("rst_wr");
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 8'h03, 0);
    cyc(0, 8'h00, 0, 8'h04, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    chk("rst_wr_dropped", 32'(ofifo_em), 32'd1);
    frame(16, -1, 0, 0, 2);
    rd_n(5);

    // reset during a read
    do_reset("rst_rd");
    cyc(0, 8'h00, 0, 8'h00, 0);
    frame(8, -1, 0, 0, 2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
